// File: rtl/riscv_arb_pkg.sv
// Shared types and default widths for the fetch/data memory port arbiter.
package riscv_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE_IF,
        ISSUE_DM,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Wait-cycle counter for an outstanding memory request; expired is raised on the
// cycle whose increment would bring the count up to limit.
module arb_timeout_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] cnt;
    logic [8:0] cnt_nxt;

    assign cnt_nxt = {1'b0, cnt} + 9'd1;
    assign expired = en && (cnt_nxt >= {1'b0, limit});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt_nxt[7:0];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one req/ack memory port between fetch and data stages.
// Optional contention counter built only when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                err,
    output logic [31:0]         perf_conflict
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    arb_state_t state;
    owner_t     ptr;
    logic       to_clr;
    logic       to_en;
    logic       to_expired;

    assign to_clr = !(state == ISSUE_IF || state == ISSUE_DM);
    assign to_en  = !to_clr && !mem_ack;

    arb_timeout_cnt u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (to_clr),
        .en      (to_en),
        .limit   (WAIT_LIMIT),
        .expired (to_expired)
    );

    // The mem_* outputs double as the latched request, so they stay stable through ISSUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= OWN_DM;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            err       <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req && (!dm_req || ptr == OWN_IF)) begin
                        state     <= ISSUE_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                        if (dm_req) ptr <= OWN_DM;
                    end else if (dm_req) begin
                        state     <= ISSUE_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_be    <= dm_be;
                        if (if_req) ptr <= OWN_IF;
                    end
                end
                ISSUE_IF, ISSUE_DM: begin
                    // A timeout completes the request like an ack, but with zero data and err set.
                    if (mem_ack || to_expired) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        if (!mem_ack) err <= 1'b1;
                        if (state == ISSUE_IF) begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            dm_ready <= 1'b1;
                            if (!mem_ack) dm_rdata <= '0;
                            else if (!mem_we) dm_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    logic [31:0] conflict_cnt;

    // Only one side is ever serviced, so any cycle with both requests high is contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (if_req && dm_req) begin
            conflict_cnt <= sat_inc(conflict_cnt);
        end
    end

    assign perf_conflict = conflict_cnt;
`else
    assign perf_conflict = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model with a behavioural memory.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int BE_W     = DATA_W / 8;
    localparam int MAX_WAIT = 15;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [BE_W-1:0]   dm_be;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              err;
    logic [31:0]       perf_conflict;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_delay;
    int ack_cnt;
    bit req_seen;
    logic [31:0] mem_img [logic [31:0]];

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_rdata      (if_rdata),
        .if_ready      (if_ready),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_be         (dm_be),
        .dm_rdata      (dm_rdata),
        .dm_ready      (dm_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .err           (err),
        .perf_conflict (perf_conflict)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] v;
        v = mem_read(a);
        for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
        mem_img[a] = v;
    endtask

    // Advance one clock; the memory answers after ack_delay wait cycles (negative = never).
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_req === 1'b1) begin
            if (!req_seen) begin
                ack_cnt  = 0;
                req_seen = 1'b1;
            end else begin
                ack_cnt++;
            end
        end else begin
            req_seen = 1'b0;
        end
        mem_ack   = (mem_req === 1'b1) && (ack_delay >= 0) && (ack_cnt == ack_delay);
        mem_rdata = mem_ack ? mem_read(mem_addr) : $urandom();
        if (mem_ack && mem_we) mem_write(mem_addr, mem_wdata, mem_be);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        if_req  = 1'b0;
        dm_req  = 1'b0;
        mem_ack = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        n_checks++; if ({mem_addr, mem_wdata, mem_be, mem_we} !== '0) begin n_fail++; $display("FAIL rst_mem_bus: got addr=%h wdata=%h be=%h we=%b want all 0", mem_addr, mem_wdata, mem_be, mem_we); end
        n_checks++; if ({if_ready, dm_ready, err} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got if_ready/dm_ready/err=%b%b%b want 000", if_ready, dm_ready, err); end
        n_checks++; if ({if_rdata, dm_rdata} !== '0) begin n_fail++; $display("FAIL rst_rdata: got if=%h dm=%h want 0", if_rdata, dm_rdata); end
        n_checks++; if (perf_conflict !== 32'd0) begin n_fail++; $display("FAIL rst_perf: got %0d want 0", perf_conflict); end
        tick();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_idle_stay: got mem_req=%b want 0", mem_req); end
    endtask

    task automatic test_single_fetch();
        do_reset();
        mem_img[32'h10] = 32'h0050_0093;
        ack_delay = 0;
        if_req  = 1'b1;
        if_addr = 32'h10;
        tick();
        n_checks++; if ({mem_req, mem_we} !== 2'b10) begin n_fail++; $display("FAIL fetch_req: got req/we=%b%b want 10", mem_req, mem_we); end
        n_checks++; if (mem_addr !== 32'h10 || mem_be !== 4'hF) begin n_fail++; $display("FAIL fetch_addr: got addr=%h be=%h want 00000010/f", mem_addr, mem_be); end
        tick();
        n_checks++; if ({if_ready, dm_ready, mem_req} !== 3'b100) begin n_fail++; $display("FAIL fetch_ready: got if/dm/req=%b%b%b want 100", if_ready, dm_ready, mem_req); end
        n_checks++; if (if_rdata !== 32'h0050_0093) begin n_fail++; $display("FAIL fetch_rdata: got %h want 00500093", if_rdata); end
        if_req = 1'b0;
        tick();
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse: got if_ready=%b want 0", if_ready); end
    endtask

    task automatic test_contention();
        do_reset();
        ack_delay = 0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'hF;
        if_req = 1'b1; if_addr = 32'h20;
        tick();
        n_checks++; if ({mem_req, mem_we, mem_be} !== 6'b11_1111 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL cont_dm_first: got req=%b we=%b be=%h addr=%h wdata=%h want 1/1/f/100/deadbeef", mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        tick();
        n_checks++; if ({if_ready, dm_ready} !== 2'b01) begin n_fail++; $display("FAIL cont_dm_ready: got if/dm=%b%b want 01", if_ready, dm_ready); end
        dm_we = 1'b0;
        tick();
        tick();
        n_checks++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h20) begin n_fail++; $display("FAIL cont_if_next: got req=%b we=%b addr=%h want 1/0/00000020", mem_req, mem_we, mem_addr); end
        tick();
        n_checks++; if ({if_ready, dm_ready} !== 2'b10 || if_rdata !== 32'h0020_FFDF) begin n_fail++; $display("FAIL cont_if_ready: got if/dm=%b%b rdata=%h want 10/0020ffdf", if_ready, dm_ready, if_rdata); end
        if_addr = 32'h24;
        tick();
        tick();
        n_checks++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL cont_dm_again: got req=%b we=%b addr=%h want 1/0/00000100", mem_req, mem_we, mem_addr); end
        tick();
        n_checks++; if (dm_ready !== 1'b1 || dm_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cont_readback: got dm_ready=%b rdata=%h want 1/deadbeef", dm_ready, dm_rdata); end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_wait_states();
        do_reset();
        ack_delay = 3;
        mem_img[32'h200] = 32'h1234_5678;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_wdata = $urandom(); dm_be = 4'($urandom_range(0, 15));
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({mem_req, mem_we, dm_ready, if_ready} !== 4'b1000 || mem_addr !== 32'h200) begin
                n_fail++; $display("FAIL wait_stable[%0d]: got req/we/dm_rdy/if_rdy=%b%b%b%b addr=%h want 1000/00000200", i, mem_req, mem_we, dm_ready, if_ready, mem_addr);
            end
            if (i == 1) begin dm_addr = 32'h204; dm_we = 1'b1; end
            tick();
        end
        n_checks++; if ({dm_ready, if_ready, mem_req} !== 3'b100 || dm_rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL wait_ready: got dm/if/req=%b%b%b rdata=%h want 100/12345678", dm_ready, if_ready, mem_req, dm_rdata);
        end
        dm_req = 1'b0;
        tick();
        n_checks++; if (dm_ready !== 1'b0) begin n_fail++; $display("FAIL wait_pulse: got dm_ready=%b want 0", dm_ready); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        ack_delay = 0;
        if_req = 1'b1; if_addr = 32'h44;
        repeat (2) tick();
        if_req = 1'b0;
        tick();
        ack_delay = -1;
        if_req = 1'b1; if_addr = 32'h40;
        tick();
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        n_checks++; if (n !== MAX_WAIT) begin n_fail++; $display("FAIL to_cycles: got %0d mem_req cycles want %0d", n, MAX_WAIT); end
        n_checks++; if ({if_ready, dm_ready, err} !== 3'b101) begin n_fail++; $display("FAIL to_resp: got if/dm/err=%b%b%b want 101", if_ready, dm_ready, err); end
        n_checks++; if (if_rdata !== 32'd0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", if_rdata); end
        if_req = 1'b0;
        repeat (5) tick();
        n_checks++; if ({err, mem_req, if_ready} !== 3'b100) begin n_fail++; $display("FAIL to_sticky: got err/req/if_rdy=%b%b%b want 100", err, mem_req, if_ready); end
        do_reset();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got err=%b want 0", err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ack_delay = -1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = $urandom() | 32'h1; dm_be = 4'hF;
        repeat (2) tick();
        n_checks++; if ({mem_req, mem_we} !== 2'b11) begin n_fail++; $display("FAIL mid_pre: got req/we=%b%b want 11", mem_req, mem_we); end
        #3 reset = 1'b1;
        #1;
        n_checks++; if ({mem_req, mem_we, mem_be, if_ready, dm_ready, err} !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++; $display("FAIL mid_async: got req=%b we=%b be=%h addr=%h wdata=%h rdy=%b%b err=%b want all 0", mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ready, dm_ready, err);
        end
        dm_req = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1;
            tick();
            n_checks++; if ({if_ready, dm_ready, mem_req} !== 3'b000) begin n_fail++; $display("FAIL mid_stray_ack[%0d]: got if/dm/req=%b%b%b want 000", i, if_ready, dm_ready, mem_req); end
        end
        ack_delay = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        repeat (2) tick();
        n_checks++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h0300_FCFF) begin n_fail++; $display("FAIL mid_recover: got dm_ready=%b rdata=%h want 1/0300fcff", dm_ready, dm_rdata); end
        dm_req = 1'b0;
        tick();
    endtask

    task automatic test_perf();
        int exp_cnt;
        do_reset();
        ack_delay = 0;
        if_req = 1'b1; if_addr = 32'h8;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hC;
        repeat (5) tick();
        if_req = 1'b0; dm_req = 1'b0;
        repeat (4) tick();
`ifdef ARB_PERF_CNT_EN
        exp_cnt = 5;
`else
        exp_cnt = 0;
`endif
        n_checks++; if (perf_conflict !== 32'(exp_cnt)) begin n_fail++; $display("FAIL perf_count: got %0d want %0d", perf_conflict, exp_cnt); end
    endtask

    task automatic test_random();
        bit busy, ptr_dm, own_dm, exp_grant, p_if, p_dm, ack_prev, if_pend, dm_pend;
        int hold, conf_m, exp_perf;
        logic [31:0] e_addr, e_wdata, e_rdata, if_rd_m, dm_rd_m;
        logic        e_we;
        logic [3:0]  e_be;
        busy = 0; ptr_dm = 1; own_dm = 0; if_pend = 0; dm_pend = 0;
        hold = 0; conf_m = 0;
        e_addr = '0; e_wdata = '0; e_rdata = '0; e_we = 0; e_be = '0;
        if_rd_m = '0; dm_rd_m = '0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!if_pend && cyc < 500 && $urandom_range(0, 1) == 1) begin
                if_pend = 1; if_req = 1'b1; if_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!dm_pend && cyc < 500 && $urandom_range(0, 1) == 1) begin
                dm_pend = 1; dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = 32'($urandom_range(0, 15)) << 2; dm_wdata = $urandom(); dm_be = 4'($urandom_range(0, 15));
            end
            if (!busy) ack_delay = $urandom_range(0, 3);
            exp_grant = !busy && hold == 0 && (if_req || dm_req);
            p_if = if_req; p_dm = dm_req; ack_prev = mem_ack;
            if (p_if && p_dm) conf_m++;
            if (hold > 0) hold--;
            tick();
            if (busy && ack_prev) begin
                n_checks++; if ({if_ready, dm_ready, mem_req} !== (own_dm ? 3'b010 : 3'b100)) begin
                    n_fail++; $display("FAIL rnd_ready cyc%0d: got if/dm/req=%b%b%b owner_dm=%b", cyc, if_ready, dm_ready, mem_req, own_dm);
                end
                if (own_dm) begin
                    if (!e_we) dm_rd_m = e_rdata;
                    n_checks++; if (dm_rdata !== dm_rd_m) begin n_fail++; $display("FAIL rnd_dm_rdata cyc%0d: got %h want %h", cyc, dm_rdata, dm_rd_m); end
                    dm_pend = 0; dm_req = 1'b0;
                end else begin
                    if_rd_m = e_rdata;
                    n_checks++; if (if_rdata !== if_rd_m) begin n_fail++; $display("FAIL rnd_if_rdata cyc%0d: got %h want %h", cyc, if_rdata, if_rd_m); end
                    if_pend = 0; if_req = 1'b0;
                end
                busy = 0; hold = 1;
            end else begin
                n_checks++; if ({if_ready, dm_ready} !== 2'b00) begin n_fail++; $display("FAIL rnd_no_ready cyc%0d: got if/dm=%b%b want 00", cyc, if_ready, dm_ready); end
                if (!busy) begin
                    n_checks++; if ((mem_req === 1'b1) !== exp_grant) begin n_fail++; $display("FAIL rnd_grant cyc%0d: got mem_req=%b want %b", cyc, mem_req, exp_grant); end
                    if (exp_grant) begin
                        own_dm = p_dm && (!p_if || ptr_dm);
                        if (p_if && p_dm) ptr_dm = !ptr_dm;
                        if (own_dm) begin
                            e_addr = dm_addr; e_we = dm_we; e_wdata = dm_wdata; e_be = dm_be;
                        end else begin
                            e_addr = if_addr; e_we = 1'b0; e_wdata = mem_wdata; e_be = 4'hF;
                        end
                        e_rdata = mem_read(e_addr);
                        busy = 1;
                    end
                end
                if (busy) begin
                    n_checks++; if (mem_req !== 1'b1 || mem_addr !== e_addr || mem_we !== e_we || mem_be !== e_be || mem_wdata !== e_wdata) begin
                        n_fail++; $display("FAIL rnd_issue cyc%0d: got req=%b addr=%h we=%b be=%h wdata=%h want 1/%h/%b/%h/%h", cyc, mem_req, mem_addr, mem_we, mem_be, mem_wdata, e_addr, e_we, e_be, e_wdata);
                    end
                end
            end
        end
        n_checks++; if (if_pend || dm_pend) begin n_fail++; $display("FAIL rnd_drain: pending if=%b dm=%b want both served", if_pend, dm_pend); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rnd_err: got %b want 0", err); end
`ifdef ARB_PERF_CNT_EN
        exp_perf = conf_m;
`else
        exp_perf = 0;
`endif
        n_checks++; if (perf_conflict !== 32'(exp_perf)) begin n_fail++; $display("FAIL rnd_perf: got %0d want %0d", perf_conflict, exp_perf); end
    endtask

    initial begin
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        ack_delay = 0; ack_cnt = 0; req_seen = 1'b0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_perf();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
